depacketizer: RTL and testbench
===============================

// Module: depacketizer
// PURPOSE
//  Receive end of the PE-to-NoC packet format: takes one flat packet from the router
//  port and splits it into its timestep, outspike and residue fields.
//  Sits between the router local output and the PE membrane/accumulate logic.
//  Buffers packets in a small FIFO and emits each field on its own valid/ready channel.
//  Malformed packets and packets addressed to another node are dropped and counted.
// PARAMETERS
//  FILTER_WIDTH  8  residue width W; packet width PW = 9+3*W (33 at default)
//  PE_NODE       0  2-bit node id this block accepts (compared with pkt[11:10])
//  FIFO_DEPTH    2  input FIFO entries; power of two, >=2
//  CHECK_NODE    1  1: drop node-id mismatches; 0: accept any node id
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst_n      in   1      synchronous reset, active low
//  in_data    in   PW     packet: [1:0] dir, [3:2] x-hop, [4] y-hop, [5] timestep, [8:6] 000,
//                         [9] outspike, [11:10] node, [8+2W:12] zeros, [8+3W:9+2W] residue
//  in_valid   in   1      packet present
//  in_ready   out  1      = !fifo_full; transfer when in_valid & in_ready at a clock edge
//  ts_data    out  1      decoded timestep
//  ts_valid   out  1      | ts_ready  in 1
//  spk_data   out  1      decoded outspike
//  spk_valid  out  1      | spk_ready in 1
//  res_data   out  W      decoded residue; valid only for timestep==1 packets
//  res_valid  out  1      | res_ready in 1
//  err_pulse  out  1      one-cycle pulse per dropped packet
//  drop_cnt   out  8      saturating count of dropped packets (sticks at 255)
// BEHAVIOUR
//  Reset (rst_n=0 at edge): FIFO emptied, FSM->IDLE, all *_valid=0, *_data=0,
//   err_pulse=0, drop_cnt=0, in_ready=1 in the following cycle. A reset mid-EMIT aborts
//   the packet with no further handshakes.
//  Each output channel: valid stays high, data stable, until valid&ready; then valid
//   drops next cycle. Ready may be high before valid.
//  A packet is malformed when pkt[8:6]!=0, pkt[8+2W:12]!=0, or (pkt[5]==0 and residue!=0).
//   Dir/x-hop/y-hop bits are ignored.
//  FSM IDLE:
//   - If the FIFO is non-empty at an edge, pop the head.
//   - Malformed, or CHECK_NODE and node!=PE_NODE: err_pulse=1 next cycle,
//     drop_cnt+=1 (saturating), stay IDLE.
//   - Otherwise register the fields; set ts_valid=1, spk_valid=1, res_valid=pkt[5]; go EMIT.
//  FSM EMIT:
//   - Each valid clears on its own handshake; channels are independent and may
//     complete in any order or in the same cycle.
//   - When the last pending handshake occurs, go IDLE.
//  Latency: packet accepted at edge N -> outputs valid after edge N+1 (FIFO empty, FSM IDLE).
//   Throughput is at most one packet per 2 cycles (no IDLE bypass).
//  FIFO: push on in_valid&in_ready; pop only in IDLE. Push and pop may occur in the same
//   cycle when not full. in_ready depends only on full, with no combinational path from any
//   output ready. Pointers wrap modulo FIFO_DEPTH, with an extra bit for full/empty.
//  drop_cnt at 255 stays 255; err_pulse still fires.
// STRUCTURE
//  Package noc_pkt_pkg holds:
//   - localparams for field offsets (DIR_LSB=0, XHOP_LSB=2, YHOP_BIT=4, TS_BIT=5,
//     SPK_BIT=9, NODE_LSB=10, ZERO_LSB=12);
//   - function pkt_width(W)=9+3*W;
//   - typedef struct for the decoded fields.
//  The packetizer side uses the same package.
//  Sub-module: sync_fifo #(WIDTH,DEPTH) (clk, rst_n, push, din, full, pop, dout, empty).
//  FSM and field decode live in depacketizer.
// TESTING (W=8, PE_NODE=0, CHECK_NODE=1, PW=33)
//  1. Packet 33'h0_0000_0200 (ts0, spk1), all readies high -> ts=0, spk=1 valid 1 cycle after
//     accept; res_valid never rises; drop_cnt=0.
//  2. Packet 33'h1_4A00_0020 (ts1, res 0xA5, spk0) -> ts=1, spk=0, res=8'hA5, all three valid.
//  3. Node mismatch 33'h0_0000_0800 -> no valids, err_pulse for 1 cycle, drop_cnt=1.
//     Reserved bit pkt[7]=1 -> dropped, drop_cnt=2.
//  4. Backpressure: res_ready=0 for 10 cycles, then 3 ts1 packets sent back to back ->
//     1st held in EMIT; FIFO holds 2, in_ready=0. Release res_ready -> residues emitted in
//     order, with no loss or duplication.
//  5. Out-of-order readies: spk_ready first, res_ready 3 cycles later, ts_ready last ->
//     each valid drops only after its own handshake; the next packet appears only after all three.
//  6. rst_n=0 for 1 cycle while in EMIT with a full FIFO -> all valids 0, in_ready=1,
//     drop_cnt=0; the next packet decodes normally. Also: 256 bad packets -> drop_cnt=255.

Source files
------------

// File: rtl/noc_pkt_pkg.sv
// Shared definitions for the PE-to-NoC packet format, used by both the
// packetizer (send side) and the depacketizer (receive side).
//
// Packet layout for residue width W (PW = 9 + 3*W bits):
//   [1:0]           dir        routing, ignored on receive
//   [3:2]           x-hop      routing, ignored on receive
//   [4]             y-hop      routing, ignored on receive
//   [5]             timestep
//   [8:6]           reserved, must be 000
//   [9]             outspike
//   [11:10]         node id
//   [8+2W:12]       zero fill, must be all zero
//   [8+3W:9+2W]     residue, must be zero when timestep==0
package noc_pkt_pkg;

  localparam int unsigned DIR_LSB  = 0;
  localparam int unsigned XHOP_LSB = 2;
  localparam int unsigned YHOP_BIT = 4;
  localparam int unsigned TS_BIT   = 5;
  localparam int unsigned RSV_LSB  = 6;
  localparam int unsigned RSV_W    = 3;
  localparam int unsigned SPK_BIT  = 9;
  localparam int unsigned NODE_LSB = 10;
  localparam int unsigned NODE_W   = 2;
  localparam int unsigned ZERO_LSB = 12;

  function automatic int unsigned pkt_width(input int unsigned w);
    return 9 + 3 * w;
  endfunction

  function automatic int unsigned res_lsb(input int unsigned w);
    return 9 + 2 * w;
  endfunction

  function automatic int unsigned zero_width(input int unsigned w);
    return 2 * w - 3;
  endfunction

  // Decoded fixed-width header fields; the residue is carried separately
  // because its width is a module parameter.
  typedef struct packed {
    logic              ts;
    logic              spk;
    logic [NODE_W-1:0] node;
    logic              fmt_bad;
  } pkt_hdr_t;

  typedef enum logic {
    ST_IDLE,
    ST_EMIT
  } depkt_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered pointers carrying one extra wrap bit.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset (empties the FIFO)
//   push, din    write request/data; ignored while full
//   full         no free entry
//   pop          read request; ignored while empty
//   dout         head entry (valid while !empty)
//   empty        no stored entry
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/depacketizer.sv
// Receive side of the PE-to-NoC packet format. Buffers packets from the
// router local output in a small FIFO, checks each one, and emits its
// timestep, outspike and residue fields on independent valid/ready channels.
// Malformed or foreign-node packets are dropped and counted.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_data/valid/ready   packet input; in_ready = FIFO not full
//   ts_data/valid/ready   decoded timestep channel
//   spk_data/valid/ready  decoded outspike channel
//   res_data/valid/ready  decoded residue channel (timestep==1 packets only)
//   err_pulse             one-cycle pulse per dropped packet
//   drop_cnt              saturating dropped-packet count
module depacketizer
  import noc_pkt_pkg::*;
#(
  parameter int unsigned FILTER_WIDTH = 8,
  parameter logic [1:0]  PE_NODE      = 2'd0,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter bit          CHECK_NODE   = 1'b1,
  localparam int unsigned PW          = pkt_width(FILTER_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [PW-1:0]           in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    ts_data,
  output logic                    ts_valid,
  input  logic                    ts_ready,
  output logic                    spk_data,
  output logic                    spk_valid,
  input  logic                    spk_ready,
  output logic [FILTER_WIDTH-1:0] res_data,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic                    err_pulse,
  output logic [7:0]              drop_cnt
);

  localparam int unsigned W  = FILTER_WIDTH;
  localparam int unsigned ZW = zero_width(W);
  // Routing bits below the timestep are never used, so they are not stored.
  localparam int unsigned FW = PW - TS_BIT;

  logic          fifo_full, fifo_empty, fifo_pop;
  logic [FW-1:0] head;

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .din   (in_data[PW-1:TS_BIT]),
    .full  (fifo_full),
    .pop   (fifo_pop),
    .dout  (head),
    .empty (fifo_empty)
  );

  assign in_ready = !fifo_full;

  // Field decode of the FIFO head (indices shifted by the dropped routing bits).
  pkt_hdr_t         hdr;
  logic [W-1:0]     head_res;
  logic [RSV_W-1:0] head_rsv;
  logic [ZW-1:0]    head_zero;
  logic             head_drop;

  always_comb begin
    head_rsv    = head[RSV_LSB-TS_BIT +: RSV_W];
    head_zero   = head[ZERO_LSB-TS_BIT +: ZW];
    head_res    = head[res_lsb(W)-TS_BIT +: W];
    hdr.ts      = head[0];
    hdr.spk     = head[SPK_BIT-TS_BIT];
    hdr.node    = head[NODE_LSB-TS_BIT +: NODE_W];
    hdr.fmt_bad = (head_rsv != '0) || (head_zero != '0) ||
                  (!hdr.ts && (head_res != '0));
    head_drop   = hdr.fmt_bad || (CHECK_NODE && (hdr.node != PE_NODE));
  end

  depkt_state_e state_q, state_d;
  logic         ts_data_q, ts_data_d, ts_valid_q, ts_valid_d;
  logic         spk_data_q, spk_data_d, spk_valid_q, spk_valid_d;
  logic [W-1:0] res_data_q, res_data_d;
  logic         res_valid_q, res_valid_d;
  logic         err_q, err_d;
  logic [7:0]   cnt_q, cnt_d;

  always_comb begin
    state_d     = state_q;
    ts_data_d   = ts_data_q;
    ts_valid_d  = ts_valid_q;
    spk_data_d  = spk_data_q;
    spk_valid_d = spk_valid_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    err_d       = 1'b0;
    cnt_d       = cnt_q;
    fifo_pop    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head_drop) begin
            err_d = 1'b1;
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          end else begin
            ts_data_d   = hdr.ts;
            spk_data_d  = hdr.spk;
            res_data_d  = head_res;
            ts_valid_d  = 1'b1;
            spk_valid_d = 1'b1;
            res_valid_d = hdr.ts;
            state_d     = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        if (ts_valid_q && ts_ready)   ts_valid_d  = 1'b0;
        if (spk_valid_q && spk_ready) spk_valid_d = 1'b0;
        if (res_valid_q && res_ready) res_valid_d = 1'b0;
        if (!ts_valid_d && !spk_valid_d && !res_valid_d) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ts_data_q   <= 1'b0;
      ts_valid_q  <= 1'b0;
      spk_data_q  <= 1'b0;
      spk_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ts_data_q   <= ts_data_d;
      ts_valid_q  <= ts_valid_d;
      spk_data_q  <= spk_data_d;
      spk_valid_q <= spk_valid_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ts_data   = ts_data_q;
  assign ts_valid  = ts_valid_q;
  assign spk_data  = spk_data_q;
  assign spk_valid = spk_valid_q;
  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;
  assign err_pulse = err_q;
  assign drop_cnt  = cnt_q;

endmodule

// File: tb/tb_depacketizer.sv
module tb_depacketizer;

  localparam int unsigned W  = 8;
  localparam int unsigned PW = 33;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [PW-1:0] in_data;
  logic          in_valid, in_ready;
  logic          ts_data, ts_valid, ts_ready;
  logic          spk_data, spk_valid, spk_ready;
  logic [W-1:0]  res_data;
  logic          res_valid, res_ready;
  logic          err_pulse;
  logic [7:0]    drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_drops = 0;

  always #5 clk = ~clk;

  depacketizer #(
    .FILTER_WIDTH (8),
    .PE_NODE      (2'd0),
    .FIFO_DEPTH   (2),
    .CHECK_NODE   (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ts_data   (ts_data),
    .ts_valid  (ts_valid),
    .ts_ready  (ts_ready),
    .spk_data  (spk_data),
    .spk_valid (spk_valid),
    .spk_ready (spk_ready),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .err_pulse (err_pulse),
    .drop_cnt  (drop_cnt)
  );

  // Reference rules: field values extracted by shift/modulo arithmetic.
  function automatic bit model_accept(input logic [PW-1:0] p);
    int unsigned rsv, zer, res, node, ts;
    rsv  = 32'(p >> 6) % 8;
    zer  = 32'(p >> 12) % 8192;
    res  = 32'(p >> 25) % 256;
    node = 32'(p >> 10) % 4;
    ts   = 32'(p >> 5) % 2;
    return (rsv == 0) && (zer == 0) && !(ts == 0 && res != 0) && (node == 0);
  endfunction

  function automatic logic [PW-1:0] mk_pkt(input int unsigned ts, input int unsigned spk,
                                           input int unsigned res, input int unsigned node,
                                           input int unsigned route);
    logic [PW-1:0] p;
    p = (33'(res % 256) << 25) | (33'(node % 4) << 10) | (33'(spk % 2) << 9) |
        (33'(ts % 2) << 5) | 33'(route % 32);
    return p;
  endfunction

  function automatic logic [PW-1:0] rand_good();
    int unsigned ts;
    ts = $urandom_range(0, 1);
    return mk_pkt(ts, $urandom_range(0, 1), (ts != 0) ? $urandom_range(0, 255) : 0, 0,
                  $urandom_range(0, 31));
  endfunction

  function automatic logic [PW-1:0] rand_bad();
    logic [PW-1:0] g;
    g = mk_pkt(1, $urandom_range(0, 1), $urandom_range(0, 255), 0, $urandom_range(0, 31));
    case ($urandom_range(0, 3))
      0: return mk_pkt(1, 0, $urandom_range(0, 255), $urandom_range(1, 3), $urandom_range(0, 31));
      1: return g | (33'($urandom_range(1, 7)) << 6);
      2: return g | (33'($urandom_range(1, 8191)) << 12);
      default: return mk_pkt(0, $urandom_range(0, 1), $urandom_range(1, 255), 0, $urandom_range(0, 31));
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_pkt(input logic [PW-1:0] p);
    int t;
    t = 0;
    in_data  = p;
    in_valid = 1'b1;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (!model_accept(p) && exp_drops < 255) exp_drops++;
  endtask

  task automatic set_readies(input logic t, input logic s, input logic r);
    ts_ready = t; spk_ready = s; res_ready = r;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    set_readies(0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_drops = 0;
    n_tests++;
    if ({ts_valid, spk_valid, res_valid, err_pulse} !== 4'b0) begin
      n_fail++; $display("FAIL reset_valids: got %b required 0000", {ts_valid, spk_valid, res_valid, err_pulse});
    end
    n_tests++;
    if ({ts_data, spk_data, res_data} !== 10'b0) begin
      n_fail++; $display("FAIL reset_data: got %h required 0", {ts_data, spk_data, res_data});
    end
    n_tests++;
    if (drop_cnt !== 8'd0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_cnt_ready: drop_cnt=%0d in_ready=%b required 0/1", drop_cnt, in_ready);
    end
  endtask

  task automatic test_ts0_pkt();
    set_readies(1, 1, 1);
    send_pkt(33'h0_0000_0200);
    n_tests++;
    if (ts_valid !== 1'b0) begin
      n_fail++; $display("FAIL ts0_latency: ts_valid=%b required 0 before pop edge", ts_valid);
    end
    @(negedge clk);
    n_tests++;
    if ({ts_valid, ts_data, spk_valid, spk_data, res_valid} !== 5'b10110) begin
      n_fail++; $display("FAIL ts0_fields: got %b required 10110", {ts_valid, ts_data, spk_valid, spk_data, res_valid});
    end
    @(negedge clk);
    n_tests++;
    if ({ts_valid, spk_valid, res_valid} !== 3'b0 || drop_cnt !== 8'(exp_drops)) begin
      n_fail++; $display("FAIL ts0_done: valids=%b drop_cnt=%0d required 000/%0d",
                         {ts_valid, spk_valid, res_valid}, drop_cnt, exp_drops);
    end
  endtask

  task automatic test_ts1_pkt();
    set_readies(0, 0, 0);
    send_pkt(33'h1_4A00_0020);
    @(negedge clk);
    n_tests++;
    if ({ts_valid, ts_data, spk_valid, spk_data, res_valid} !== 5'b11101 || res_data !== 8'hA5) begin
      n_fail++; $display("FAIL ts1_fields: got %b res=%h required 11101 res=a5",
                         {ts_valid, ts_data, spk_valid, spk_data, res_valid}, res_data);
    end
    set_readies(1, 1, 1);
    @(negedge clk);
    n_tests++;
    if ({ts_valid, spk_valid, res_valid} !== 3'b0) begin
      n_fail++; $display("FAIL ts1_done: valids=%b required 000", {ts_valid, spk_valid, res_valid});
    end
  endtask

  task automatic test_drop();
    logic [PW-1:0] bad [2];
    bad[0] = 33'h0_0000_0800;
    bad[1] = 33'h0_0000_0080;
    set_readies(1, 1, 1);
    for (int i = 0; i < 2; i++) begin
      send_pkt(bad[i]);
      @(negedge clk);
      n_tests++;
      if (err_pulse !== 1'b1 || drop_cnt !== 8'(exp_drops) || {ts_valid, spk_valid, res_valid} !== 3'b0) begin
        n_fail++; $display("FAIL drop_%0d: err=%b cnt=%0d valids=%b required 1/%0d/000",
                           i, err_pulse, drop_cnt, {ts_valid, spk_valid, res_valid}, exp_drops);
      end
      @(negedge clk);
      n_tests++;
      if (err_pulse !== 1'b0) begin
        n_fail++; $display("FAIL drop_pulse_width_%0d: err=%b required 0", i, err_pulse);
      end
    end
  endtask

  task automatic test_backpressure();
    int unsigned exp_res [$];
    int unsigned got_res [$];
    set_readies(1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      int unsigned r;
      r = $urandom_range(0, 255);
      exp_res.push_back(r);
      send_pkt(mk_pkt(1, $urandom_range(0, 1), r, 0, $urandom_range(0, 31)));
    end
    repeat (10) @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b0 || res_valid !== 1'b1 || 32'(res_data) !== exp_res[0]) begin
      n_fail++; $display("FAIL bp_hold: in_ready=%b res_valid=%b res=%h required 0/1/%h",
                         in_ready, res_valid, res_data, exp_res[0]);
    end
    res_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (res_valid) got_res.push_back(32'(res_data));
      @(negedge clk);
    end
    n_tests++;
    if (got_res.size() != 3) begin
      n_fail++; $display("FAIL bp_count: got %0d residues required 3", got_res.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (got_res[i] !== exp_res[i]) begin
          n_fail++; $display("FAIL bp_order_%0d: got %h required %h", i, got_res[i], exp_res[i]);
        end
      end
    end
  endtask

  task automatic test_out_of_order();
    int unsigned r1, r2, s2;
    r1 = $urandom_range(0, 255);
    r2 = $urandom_range(0, 255);
    s2 = $urandom_range(0, 1);
    set_readies(0, 0, 0);
    send_pkt(mk_pkt(1, 1, r1, 0, 3));
    send_pkt(mk_pkt(1, s2, r2, 0, 7));
    @(negedge clk);
    n_tests++;
    if ({ts_valid, spk_valid, res_valid} !== 3'b111 || 32'(res_data) !== r1) begin
      n_fail++; $display("FAIL ooo_start: valids=%b res=%h required 111/%h", {ts_valid, spk_valid, res_valid}, res_data, r1);
    end
    spk_ready = 1'b1;
    @(negedge clk);
    spk_ready = 1'b0;
    n_tests++;
    if ({ts_valid, spk_valid, res_valid} !== 3'b101) begin
      n_fail++; $display("FAIL ooo_spk: valids=%b required 101", {ts_valid, spk_valid, res_valid});
    end
    repeat (2) @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    n_tests++;
    if ({ts_valid, spk_valid, res_valid} !== 3'b100 || ts_data !== 1'b1) begin
      n_fail++; $display("FAIL ooo_res: valids=%b ts=%b required 100/1", {ts_valid, spk_valid, res_valid}, ts_data);
    end
    ts_ready = 1'b1;
    @(negedge clk);
    ts_ready = 1'b0;
    n_tests++;
    if ({ts_valid, spk_valid, res_valid} !== 3'b000) begin
      n_fail++; $display("FAIL ooo_ts: valids=%b required 000", {ts_valid, spk_valid, res_valid});
    end
    @(negedge clk);
    n_tests++;
    if ({ts_valid, spk_valid, res_valid} !== 3'b111 || 32'(spk_data) !== s2 || 32'(res_data) !== r2) begin
      n_fail++; $display("FAIL ooo_next: valids=%b spk=%b res=%h required 111/%0d/%h",
                         {ts_valid, spk_valid, res_valid}, spk_data, res_data, s2, r2);
    end
    set_readies(1, 1, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    bit exp_ts [$];
    bit exp_spk [$];
    int unsigned exp_res [$];
    bit sent_done, rx_done;
    sent_done = 0; rx_done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [PW-1:0] p;
          p = ($urandom_range(0, 3) == 0) ? rand_bad() : rand_good();
          if (model_accept(p)) begin
            exp_ts.push_back(p[5]);
            exp_spk.push_back(p[9]);
            if (p[5]) exp_res.push_back(32'(p >> 25) % 256);
          end
          send_pkt(p);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        sent_done = 1;
      end
      begin
        int c;
        c = 0;
        while (c < 4000 && !(sent_done && exp_ts.size() == 0 && exp_spk.size() == 0 && exp_res.size() == 0)) begin
          @(negedge clk);
          c++;
          if (ts_valid && ts_ready) begin
            n_tests++;
            if (exp_ts.size() == 0) begin
              n_fail++; $display("FAIL rnd_ts_extra: got ts=%b required none", ts_data);
            end else if (ts_data !== exp_ts.pop_front()) begin
              n_fail++; $display("FAIL rnd_ts: got %b required %b", ts_data, ~ts_data);
            end
          end
          if (spk_valid && spk_ready) begin
            n_tests++;
            if (exp_spk.size() == 0) begin
              n_fail++; $display("FAIL rnd_spk_extra: got spk=%b required none", spk_data);
            end else if (spk_data !== exp_spk.pop_front()) begin
              n_fail++; $display("FAIL rnd_spk: got %b required %b", spk_data, ~spk_data);
            end
          end
          if (res_valid && res_ready) begin
            n_tests++;
            if (exp_res.size() == 0) begin
              n_fail++; $display("FAIL rnd_res_extra: got res=%h required none", res_data);
            end else begin
              int unsigned e;
              e = exp_res.pop_front();
              if (32'(res_data) !== e) begin
                n_fail++; $display("FAIL rnd_res: got %h required %h", res_data, e);
              end
            end
          end
        end
        n_tests++;
        if (!sent_done || exp_ts.size() != 0 || exp_spk.size() != 0 || exp_res.size() != 0) begin
          n_fail++; $display("FAIL rnd_drain: pending ts=%0d spk=%0d res=%0d required 0",
                             exp_ts.size(), exp_spk.size(), exp_res.size());
        end
        rx_done = 1;
      end
      begin
        while (!rx_done) begin
          @(posedge clk);
          #1;
          ts_ready  = 1'($urandom_range(0, 1));
          spk_ready = 1'($urandom_range(0, 1));
          res_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    @(negedge clk);
    set_readies(1, 1, 1);
    repeat (4) @(negedge clk);
    n_tests++;
    if (drop_cnt !== 8'(exp_drops)) begin
      n_fail++; $display("FAIL rnd_drop_cnt: got %0d required %0d", drop_cnt, exp_drops);
    end
  endtask

  task automatic test_reset_mid_emit();
    set_readies(0, 0, 0);
    for (int i = 0; i < 3; i++) send_pkt(mk_pkt(1, 1, $urandom_range(1, 255), 0, 0));
    n_tests++;
    if (in_ready !== 1'b0 || ts_valid !== 1'b1) begin
      n_fail++; $display("FAIL rme_setup: in_ready=%b ts_valid=%b required 0/1", in_ready, ts_valid);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_drops = 0;
    n_tests++;
    if ({ts_valid, spk_valid, res_valid} !== 3'b0 || in_ready !== 1'b1 || drop_cnt !== 8'd0) begin
      n_fail++; $display("FAIL rme_reset: valids=%b in_ready=%b cnt=%0d required 000/1/0",
                         {ts_valid, spk_valid, res_valid}, in_ready, drop_cnt);
    end
    set_readies(1, 1, 1);
    repeat (3) @(negedge clk);
    n_tests++;
    if ({ts_valid, spk_valid, res_valid} !== 3'b0) begin
      n_fail++; $display("FAIL rme_flushed: valids=%b required 000", {ts_valid, spk_valid, res_valid});
    end
    set_readies(0, 0, 0);
    send_pkt(mk_pkt(1, 0, 8'h3C, 0, 21));
    @(negedge clk);
    n_tests++;
    if ({ts_valid, ts_data, spk_valid, spk_data, res_valid} !== 5'b11101 || res_data !== 8'h3C) begin
      n_fail++; $display("FAIL rme_next: got %b res=%h required 11101 res=3c",
                         {ts_valid, ts_data, spk_valid, spk_data, res_valid}, res_data);
    end
    set_readies(1, 1, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_saturate();
    set_readies(1, 1, 1);
    for (int i = 0; i < 257; i++) send_pkt(rand_bad());
    @(negedge clk);
    n_tests++;
    if (err_pulse !== 1'b1 || drop_cnt !== 8'(exp_drops)) begin
      n_fail++; $display("FAIL sat_last: err=%b cnt=%0d required 1/%0d", err_pulse, drop_cnt, exp_drops);
    end
    n_tests++;
    if (drop_cnt !== 8'd255) begin
      n_fail++; $display("FAIL sat_value: cnt=%0d required 255", drop_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_ts0_pkt();
    test_ts1_pkt();
    test_drop();
    test_backpressure();
    test_out_of_order();
    test_random();
    test_reset_mid_emit();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
